mem_arbiter: RTL and testbench

//   Shares one unified memory port between the nano_rv32i instruction-fetch and load/store ports.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_wait_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the unified memory port arbiter.
//   state_e : arbiter FSM states (idle, serving fetch, serving load/store)
//   gnt_e   : grant identifiers for the two requesters
//   rr_pick : round-robin winner selection between the two requesters
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // On a tie the port that was not granted last wins.
  function automatic gnt_e rr_pick(input logic i_elig, input logic d_elig, input gnt_e last);
    if (i_elig && d_elig) begin
      if (last == GNT_I) return GNT_D;
      else               return GNT_I;
    end else if (i_elig) begin
      return GNT_I;
    end else begin
      return GNT_D;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch port, load/store port and memory port
// of mem_arbiter. Signal names keep their original _i/_o suffixes, which are
// relative to the arbiter.
//   slave  : arbiter view (requests and memory response in, acks/data and memory request out)
//   master : environment view (core requesters plus memory), directions reversed
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  // fetch port
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_data_o;
  logic          i_ack_o;
  // load/store port
  logic          d_req_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [SW-1:0] d_we_i;
  logic [SW-1:0] d_rd_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          err_o;
  // memory port
  logic          m_valid_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_we_o;
  logic [SW-1:0] m_rd_o;
  logic [DW-1:0] m_rdata_i;
  logic          m_ready_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_addr_i, d_wdata_i, d_we_i, d_rd_i,
    input  m_rdata_i, m_ready_i,
    output i_data_o, i_ack_o,
    output d_rdata_o, d_ack_o, err_o,
    output m_valid_o, m_addr_o, m_wdata_o, m_we_o, m_rd_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_addr_i, d_wdata_i, d_we_i, d_rd_i,
    output m_rdata_i, m_ready_i,
    input  i_data_o, i_ack_o,
    input  d_rdata_o, d_ack_o, err_o,
    input  m_valid_o, m_addr_o, m_wdata_o, m_we_o, m_rd_o
  );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// mem_arbiter_wait_timer: watchdog counter for an outstanding memory request.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count at 0 (takes priority over en_i)
//   en_i         : count one waited cycle
//   expired_o    : count has reached TIMEOUT (saturates there)
module mem_arbiter_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (en_i && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready memory port between the instruction
// fetch port and the load/store port, round-robin on ties. The granted
// request is registered and held on the memory side until m_ready_i or a
// watchdog timeout; completion is reported with a one-cycle ack (plus err_o
// on timeout) the cycle after.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : mem_arbiter_if.slave (fetch, load/store and memory ports)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam int SW = DW / 8;

  state_e        state_q, state_d;
  gnt_e          last_q, last_d;
  logic          m_valid_q, m_valid_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [SW-1:0] m_we_q, m_we_d;
  logic [SW-1:0] m_rd_q, m_rd_d;
  logic [DW-1:0] i_data_q, i_data_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;

  logic i_elig, d_elig, grant, busy, done, tmr_expired;
  gnt_e pick;

  // A port whose ack is showing still has its req high; it must not be
  // re-granted for the request that just completed.
  assign i_elig = bus.i_req_i & ~i_ack_q;
  assign d_elig = bus.d_req_i & ~d_ack_q;
  assign grant  = (state_q == ST_IDLE) & (i_elig | d_elig);
  assign pick   = rr_pick(i_elig, d_elig, last_q);
  assign busy   = (state_q != ST_IDLE);
  assign done   = bus.m_ready_i | tmr_expired;

  mem_arbiter_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (grant),
    .en_i      (busy & ~bus.m_ready_i),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = m_we_q;
    m_rd_d    = m_rd_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          last_d    = pick;
          m_valid_d = 1'b1;
          if (pick == GNT_I) begin
            state_d   = ST_BUSY_I;
            m_addr_d  = bus.i_addr_i;
            m_wdata_d = '0;
            m_we_d    = '0;
            m_rd_d    = '1;
          end else begin
            state_d   = ST_BUSY_D;
            m_addr_d  = bus.d_addr_i;
            m_wdata_d = bus.d_wdata_i;
            m_we_d    = bus.d_we_i;
            // write strobes win over read strobes
            m_rd_d    = (bus.d_we_i != '0) ? '0 : bus.d_rd_i;
          end
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        // m_ready_i takes precedence over an expiring watchdog
        if (done) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
          m_we_d    = '0;
          m_rd_d    = '0;
          err_d     = ~bus.m_ready_i;
          if (state_q == ST_BUSY_I) begin
            i_ack_d  = 1'b1;
            i_data_d = bus.m_ready_i ? bus.m_rdata_i : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = (bus.m_ready_i && m_we_q == '0) ? bus.m_rdata_i : '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= GNT_D;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_we_q    <= '0;
      m_rd_q    <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
      m_rd_q    <= m_rd_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_valid_o = m_valid_q;
  assign bus.m_addr_o  = m_addr_q;
  assign bus.m_wdata_o = m_wdata_q;
  assign bus.m_we_o    = m_we_q;
  assign bus.m_rd_o    = m_rd_q;
  assign bus.i_data_o  = i_data_q;
  assign bus.i_ack_o   = i_ack_q;
  assign bus.d_rdata_o = d_rdata_q;
  assign bus.d_ack_o   = d_ack_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for the documented corner cases,
// then randomized traffic checked cycle by cycle against a transaction-level
// model, then a sustained-contention run checked for fairness.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, ireq, dreq;
    logic [3:0]  dwe, drd;
    logic        rdy;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] ea;
    logic [3:0]  ewe, erd;
    logic        eia, eda, eerr;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t v(input logic rst, ireq, dreq, input logic [3:0] dwe, drd,
                             input logic rdy, input logic [31:0] rdata,
                             input logic ev, input logic [31:0] ea, input logic [3:0] ewe, erd,
                             input logic eia, eda, eerr, input logic [31:0] ed);
    vec_t r;
    r.rst = rst; r.ireq = ireq; r.dreq = dreq; r.dwe = dwe; r.drd = drd;
    r.rdy = rdy; r.rdata = rdata; r.ev = ev; r.ea = ea; r.ewe = ewe; r.erd = erd;
    r.eia = eia; r.eda = eda; r.eerr = eerr; r.ed = ed;
    return r;
  endfunction

  vec_t vt[$];

  task automatic run_table();
    // rst ireq dreq dwe drd rdy rdata | ev ea ewe erd | iack dack err data
    // 1: fetch, zero-wait
    vt.push_back(v(1,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,0,0,0,1,32'hDEADBEEF, 1,32'h10,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         1,0,0,32'hDEADBEEF));
    vt.push_back(v(0,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    // 2: tie from reset, fetch first, data granted in fetch ack cycle
    vt.push_back(v(1,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,1,0,4'hF,0,0,         0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,1,0,4'hF,1,32'h11111111, 1,32'h10,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,1,1,0,4'hF,0,0,         0,0,0,0,         1,0,0,32'h11111111));
    vt.push_back(v(0,0,1,0,4'hF,1,32'h22222222, 1,32'h20,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,0,1,0,4'hF,0,0,         0,0,0,0,         0,1,0,32'h22222222));
    vt.push_back(v(0,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    // 3: store with 3 wait states, read strobes suppressed, store ack data 0
    vt.push_back(v(0,0,1,4'h3,4'hF,0,0,      0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,0,1,4'h3,4'hF,0,0,      1,32'h20,4'h3,0, 0,0,0,0));
    vt.push_back(v(0,0,1,4'h3,4'hF,0,0,      1,32'h20,4'h3,0, 0,0,0,0));
    vt.push_back(v(0,0,1,4'h3,4'hF,0,0,      1,32'h20,4'h3,0, 0,0,0,0));
    vt.push_back(v(0,0,1,4'h3,4'hF,1,32'h33333333, 1,32'h20,4'h3,0, 0,0,0,0));
    vt.push_back(v(0,0,1,4'h3,4'hF,0,0,      0,0,0,0,         0,1,0,0));
    vt.push_back(v(0,0,0,0,0,1,32'h77,       0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    // 4: timeout after 5 valid cycles, then a normal fetch with one wait
    vt.push_back(v(0,0,1,0,4'hF,0,0,         0,0,0,0,         0,0,0,0));
    for (int k = 0; k < 5; k++)
      vt.push_back(v(0,0,1,0,4'hF,0,0,       1,32'h20,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,0,1,0,4'hF,0,0,         0,0,0,0,         0,1,1,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            1,32'h10,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,1,0,0,0,1,32'h44444444, 1,32'h10,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         1,0,0,32'h44444444));
    vt.push_back(v(0,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    // 6: reset during a data access, pending fetch served afterwards
    vt.push_back(v(0,0,1,0,4'hF,0,0,         0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,1,0,4'hF,0,0,         1,32'h20,0,4'hF, 0,0,0,0));
    vt.push_back(v(1,1,1,0,4'hF,0,0,         0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         0,0,0,0));
    vt.push_back(v(0,1,0,0,0,1,32'h55555555, 1,32'h10,0,4'hF, 0,0,0,0));
    vt.push_back(v(0,1,0,0,0,0,0,            0,0,0,0,         1,0,0,32'h55555555));
    vt.push_back(v(0,0,0,0,0,0,0,            0,0,0,0,         0,0,0,0));

    bus.i_addr_i  = 32'h10;
    bus.d_addr_i  = 32'h20;
    bus.d_wdata_i = 32'hCAFEF00D;
    foreach (vt[k]) begin
      @(posedge clk); #1;
      rst           = vt[k].rst;
      bus.i_req_i   = vt[k].ireq;
      bus.d_req_i   = vt[k].dreq;
      bus.d_we_i    = vt[k].dwe;
      bus.d_rd_i    = vt[k].drd;
      bus.m_ready_i = vt[k].rdy;
      bus.m_rdata_i = vt[k].rdata;
      @(negedge clk);
      chk($sformatf("r%0d m_valid", k), bus.m_valid_o, vt[k].ev);
      chk($sformatf("r%0d m_we", k),    bus.m_we_o,    vt[k].ewe);
      chk($sformatf("r%0d m_rd", k),    bus.m_rd_o,    vt[k].erd);
      chk($sformatf("r%0d i_ack", k),   bus.i_ack_o,   vt[k].eia);
      chk($sformatf("r%0d d_ack", k),   bus.d_ack_o,   vt[k].eda);
      chk($sformatf("r%0d err", k),     bus.err_o,     vt[k].eerr);
      if (vt[k].ev) chk($sformatf("r%0d m_addr", k), bus.m_addr_o, vt[k].ea);
      if (vt[k].ewe != 0) chk($sformatf("r%0d m_wdata", k), bus.m_wdata_o, 32'hCAFEF00D);
      if (vt[k].eia) chk($sformatf("r%0d i_data", k), bus.i_data_o, vt[k].ed);
      if (vt[k].eda) chk($sformatf("r%0d d_rdata", k), bus.d_rdata_o, vt[k].ed);
    end
  endtask

  // ---------------- randomized traffic with reference model ----------------
  typedef struct {
    logic [31:0] a, wd;
    logic [3:0]  we, rd;
  } txn_t;

  // Port 0 = fetch, 1 = load/store.
  txn_t        rq[2];
  logic        act[2], drp[2], gnt[2];
  // Model: one access outstanding at most; ackp = port acked this cycle or -1.
  logic        mb;
  int          mown, mk, mw, mlast, ackp;
  txn_t        mt;
  logic        aerr;
  logic [31:0] adata;
  int          ci, cd;

  // What the memory port must show for a request from port p.
  function automatic txn_t mfields(input int p, input txn_t t);
    txn_t r = t;
    if (p == 0) begin
      r.we = '0;
      r.rd = '1;
    end else if (t.we != 0) begin
      r.rd = '0;
    end
    return r;
  endfunction

  task automatic model_reset();
    rst = 1'b1;
    bus.i_req_i = 0; bus.d_req_i = 0; bus.m_ready_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mb = 0; mlast = 1; ackp = -1; mk = 0; mw = 0; mown = 0;
    aerr = 0; adata = '0;
    for (int p = 0; p < 2; p++) begin act[p] = 0; drp[p] = 0; gnt[p] = 0; end
  endtask

  task automatic run_random(input int ncyc, input bit contend);
    int nackp, win;
    logic naerr, rdy, ei, ed;
    logic [31:0] nadata;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      chk("rnd m_valid", bus.m_valid_o, mb);
      if (mb) begin
        chk("rnd m_addr", bus.m_addr_o, mt.a);
        chk("rnd m_we", bus.m_we_o, mt.we);
        chk("rnd m_rd", bus.m_rd_o, mt.rd);
        if (mt.we != 0) chk("rnd m_wdata", bus.m_wdata_o, mt.wd);
      end else begin
        chk("rnd idle m_we", bus.m_we_o, 0);
        chk("rnd idle m_rd", bus.m_rd_o, 0);
      end
      chk("rnd i_ack", bus.i_ack_o, ackp == 0);
      chk("rnd d_ack", bus.d_ack_o, ackp == 1);
      chk("rnd err", bus.err_o, ackp >= 0 && aerr);
      if (ackp == 0) chk("rnd i_data", bus.i_data_o, adata);
      if (ackp == 1) chk("rnd d_rdata", bus.d_rdata_o, adata);
      if (contend) begin ci += bus.i_ack_o; cd += bus.d_ack_o; end

      // requesters
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && (contend || $urandom_range(0, 2) == 0)) begin
          act[p] = 1; drp[p] = 0; gnt[p] = 0;
          rq[p].a  = $urandom;
          rq[p].wd = $urandom;
          rq[p].we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          rq[p].rd = 4'($urandom);
        end else if (act[p] && gnt[p] && ackp != p && !drp[p] && !contend &&
                     $urandom_range(0, 7) == 0) begin
          // drop req mid-access and scramble the request fields
          drp[p] = 1;
          rq[p].a = $urandom; rq[p].wd = $urandom; rq[p].we = 4'($urandom); rq[p].rd = 4'($urandom);
        end
      end
      bus.i_req_i   = act[0] && !drp[0];
      bus.i_addr_i  = rq[0].a;
      bus.d_req_i   = act[1] && !drp[1];
      bus.d_addr_i  = rq[1].a;
      bus.d_wdata_i = rq[1].wd;
      bus.d_we_i    = rq[1].we;
      bus.d_rd_i    = rq[1].rd;
      rdy = mb ? (mk == mw) : ($urandom_range(0, 3) == 0);
      bus.m_ready_i = rdy;
      bus.m_rdata_i = $urandom;

      // advance model to next cycle
      nackp = -1; naerr = 0; nadata = '0;
      if (mb) begin
        if (rdy) begin
          nackp = mown;
          nadata = (mown == 1 && mt.we != 0) ? 32'h0 : bus.m_rdata_i;
          mb = 0;
        end else if (mk == TO) begin
          nackp = mown; naerr = 1; mb = 0;
        end else begin
          mk++;
        end
      end else begin
        ei = bus.i_req_i && ackp != 0;
        ed = bus.d_req_i && ackp != 1;
        if (ei || ed) begin
          win = (ei && ed) ? 1 - mlast : (ei ? 0 : 1);
          mlast = win; mb = 1; mown = win; mk = 0;
          mt = mfields(win, rq[win]);
          gnt[win] = 1;
          mw = contend ? 0 : (($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TO - 1));
        end
      end
      if (ackp >= 0) begin act[ackp] = 0; drp[ackp] = 0; gnt[ackp] = 0; end
      ackp = nackp; aerr = naerr; adata = nadata;
    end
  endtask

  initial begin
    bus.i_req_i = 0; bus.i_addr_i = '0;
    bus.d_req_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_we_i = '0; bus.d_rd_i = '0;
    bus.m_ready_i = 0; bus.m_rdata_i = '0;

    run_table();

    model_reset();
    run_random(2000, 1'b0);

    ci = 0; cd = 0;
    run_random(40, 1'b1);
    chk("contend i acks", ci >= 6, 1);
    chk("contend d acks", cd >= 6, 1);
    chk("contend balance", (ci - cd <= 1) && (cd - ci <= 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
